ln_arg_div: RTL and testbench
=============================

Name: ln_arg_div

Overview:
- Streaming pre-stage for the natural-log path. Accepts a positive Q16 value x and produces z = (x-1)/(x+1) in Q16.
- Feeds cordic_arctanh directly: z is always in (-1,1), and ln(x) = 2*arctanh(z).
- Fully pipelined radix-2 restoring divider. Accepts one sample per clock; no back-pressure.

Parameters:
- FRAC_BITS, 16, quotient fractional bits; equals the Q format of iData and oData. Latency scales with it.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- iData  input  32  signed Q16 x; valid domain x > 0
- pre_vaild  input  1  iData qualifier, may be high every cycle
- oData  output  32  signed Q16 z = (x-1)/(x+1); connects to cordic_arctanh iData
- post_vaild  output  1  oData qualifier; connects to cordic_arctanh pre_vaild
- oErr  output  1  high with post_vaild when the input had x <= 0

Behaviour:
- Reset: one clock; asynchronous active-low reset rst_n. All pipeline registers clear; oData=0, post_vaild=0, oErr=0.
- Reset mid-operation: all in-flight samples are discarded; no valid is emitted for them after reset release.
- Stage 0 (input register):
  - num = x - 65536 (33-bit signed); den = x + 65536 (33-bit unsigned, never wraps).
  - neg = num<0; r0 = |num|; err = (x<=0); valid = pre_vaild.
  - When err=1, r0 is forced to 0 so downstream arithmetic stays bounded.
- Stages 1..FRAC_BITS, one restoring step each:
  - r' = r<<1 (34-bit).
  - If r' >= den: r = r' - den and q bit = 1; else r = r' and q bit = 0.
  - q shifts in MSB-first. den, neg, err and valid travel alongside.
- Invariant: r < den always holds, so the integer quotient part is 0 and |q| <= 2^FRAC_BITS - 1.
- Output register: oData = neg ? -q : q, sign-extended to 32 bits. If err=1, oData = 0. post_vaild = valid; oErr = err & valid.
- Latency: FRAC_BITS+2 clocks from pre_vaild to post_vaild, i.e. 18 at default. Throughput is 1 sample/clk.
- Bubbles are preserved: post_vaild mirrors the pre_vaild pattern delayed by the latency.
- Rounding: the magnitude is truncated, then negated (round toward zero).
- Payload registers may update when the valid bit is low. oData is only defined while post_vaild=1.
- Total arctanh-based ln path latency = (FRAC_BITS+2) + (PIPELINE+2).

Optional Feature:
- Macro LN_ARG_DIV_ROUND_EN.
- When defined:
  - One extra restoring stage computes a guard bit.
  - Magnitude = q + guard, clamped to 2^FRAC_BITS - 1 so the result stays strictly inside arctanh's domain.
  - Result is round-half-up on magnitude; latency becomes FRAC_BITS+3.
- When undefined: truncation as described above; latency FRAC_BITS+2.

Decomposition:
- Shared package holds:
  - Q16 constants: Q16_ONE = 65536, FRAC_BITS default 16.
  - Data width 32; remainder width 34; den width 33.
  - Latency formula constant, shared with the arctanh and ln top levels.
- One natural sub-module, ln_arg_div_stage: a single registered restoring step.
  - In/out: r, q, den, neg, err, valid.
  - Instantiated FRAC_BITS times (+1 with LN_ARG_DIV_ROUND_EN) via generate.

Test Plan:
- Single samples, default build:
  - x=196608 (3.0) -> oData=32768, oErr=0, 18 clocks after pre_vaild.
  - x=65536 -> 0.
  - x=32768 -> -21845.
  - x=327680 (5.0) -> 43690.
- Domain edges:
  - x=2147483647 -> 65532.
  - x=1 -> -65534.
  - x=0 and x=-65536 -> oData=0, oErr=1, post_vaild=1.
- Streaming: 5 back-to-back valids x=65536*{2,3,4,5,6} -> outputs {21845, 32768, 39321, 43690, 46811} on 5 consecutive cycles starting at latency 18. Then a gap of 3 invalid cycles is reproduced on post_vaild.
- Reset mid-stream: assert rst_n=0 for 2 cycles while 10 samples are in flight -> outputs clear asynchronously; zero post_vaild pulses afterwards until new input.
- LN_ARG_DIV_ROUND_EN build:
  - x=327680 -> 43691; x=32768 -> -21845; x=2147483647 -> 65532.
  - Latency 19.
  - Random x in [1, 2^31-1] vs a golden model: |error| <= 0.5 LSB.
- Chained with cordic_arctanh (PIPELINE=16): x=196608 -> 2*arctanh result ≈ 72000 (ln3 = 1.0986), within CORDIC tolerance, after 36 clocks total.

Source files
------------

// File: rtl/ln_arg_div_pkg.sv
// ln_arg_div_pkg: shared Q16 constants, widths and latency helpers for the ln argument divider.
// LN_ARG_DIV_ROUND_EN adds one guard-bit stage to the divider latency.
package ln_arg_div_pkg;
  localparam int Q16_ONE = 65536;
  localparam int FRAC_BITS_DEF = 16;
  localparam int DATA_W = 32;
  localparam int REM_W = 34;
  localparam int DEN_W = 33;
`ifdef LN_ARG_DIV_ROUND_EN
  localparam int ROUND_STAGES = 1;
`else
  localparam int ROUND_STAGES = 0;
`endif
  localparam int LATENCY = FRAC_BITS_DEF + 2 + ROUND_STAGES;
  function automatic int ln_arg_div_latency(input int frac_bits);
    return frac_bits + 2 + ROUND_STAGES;
  endfunction
  function automatic int ln_path_latency(input int frac_bits, input int pipeline);
    return ln_arg_div_latency(frac_bits) + pipeline + 2;
  endfunction
endpackage

// File: rtl/ln_arg_div_stage.sv
// ln_arg_div_stage: one registered radix-2 restoring division step, quotient shifted in MSB-first.
module ln_arg_div_stage
  import ln_arg_div_pkg::*;
#(
  parameter int QW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REM_W-1:0] r,
  input  logic [QW-1:0]    q,
  input  logic [DEN_W-1:0] den,
  input  logic             neg,
  input  logic             err,
  input  logic             valid,
  output logic [REM_W-1:0] nx_r,
  output logic [QW-1:0]    nx_q,
  output logic [DEN_W-1:0] nx_den,
  output logic             nx_neg,
  output logic             nx_err,
  output logic             nx_valid
);
  logic [REM_W-1:0] sh;
  logic ge;
  // r < den keeps r<<1 inside REM_W bits, so the dropped MSB is always zero
  assign sh = r << 1;
  assign ge = sh >= {1'b0, den};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nx_r <= '0;
      nx_q <= '0;
      nx_den <= '0;
      nx_neg <= 1'b0;
      nx_err <= 1'b0;
      nx_valid <= 1'b0;
    end else begin
      nx_r <= ge ? sh - {1'b0, den} : sh;
      nx_q <= {q[QW-2:0], ge};
      nx_den <= den;
      nx_neg <= neg;
      nx_err <= err;
      nx_valid <= valid;
    end
endmodule

// File: rtl/ln_arg_div.sv
// ln_arg_div: pipelined z = (x-1)/(x+1) in Q16 for the arctanh-based ln path.
// LN_ARG_DIV_ROUND_EN: extra guard stage, round-half-up magnitude clamped below 1.0.
module ln_arg_div
  import ln_arg_div_pkg::*;
#(
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] iData,
  input  logic                     pre_vaild,
  output logic signed [DATA_W-1:0] oData,
  output logic                     post_vaild,
  output logic                     oErr
);
  localparam int NS = FRAC_BITS + ROUND_STAGES;
  logic [REM_W-1:0] r [NS+1];
  logic [NS-1:0] q [NS+1];
  logic [DEN_W-1:0] den [NS+1];
  logic [NS:0] neg, err, valid;
  logic signed [DEN_W-1:0] num;
  logic [DEN_W-1:0] mag0;
  logic x_bad;
  logic [FRAC_BITS:0] mag;
  assign num = {iData[DATA_W-1], iData} - DEN_W'(Q16_ONE);
  assign mag0 = num[DEN_W-1] ? DEN_W'(-num) : DEN_W'(num);
  assign x_bad = iData[DATA_W-1] | ~|iData;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r[0] <= '0;
      q[0] <= '0;
      den[0] <= '0;
      neg[0] <= 1'b0;
      err[0] <= 1'b0;
      valid[0] <= 1'b0;
    end else begin
      r[0] <= x_bad ? '0 : {1'b0, mag0};
      q[0] <= '0;
      den[0] <= {1'b0, iData} + DEN_W'(Q16_ONE);
      neg[0] <= num[DEN_W-1];
      err[0] <= x_bad;
      valid[0] <= pre_vaild;
    end
  for (genvar i = 0; i < NS; i++) begin : g_stage
    ln_arg_div_stage #(.QW(NS)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .r        (r[i]),
      .q        (q[i]),
      .den      (den[i]),
      .neg      (neg[i]),
      .err      (err[i]),
      .valid    (valid[i]),
      .nx_r     (r[i+1]),
      .nx_q     (q[i+1]),
      .nx_den   (den[i+1]),
      .nx_neg   (neg[i+1]),
      .nx_err   (err[i+1]),
      .nx_valid (valid[i+1])
    );
  end
`ifdef LN_ARG_DIV_ROUND_EN
  logic [FRAC_BITS:0] sum;
  assign sum = {1'b0, q[NS][NS-1:1]} + (FRAC_BITS+1)'(q[NS][0]);
  // a carry into 1.0 would leave arctanh's open domain, so saturate one LSB below
  assign mag = sum[FRAC_BITS] ? {1'b0, {FRAC_BITS{1'b1}}} : sum;
`else
  assign mag = {1'b0, q[NS]};
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      oData <= '0;
      post_vaild <= 1'b0;
      oErr <= 1'b0;
    end else begin
      oData <= err[NS] ? '0 : neg[NS] ? -DATA_W'(mag) : DATA_W'(mag);
      post_vaild <= valid[NS];
      oErr <= err[NS] & valid[NS];
    end
endmodule

// File: tb/tb_ln_arg_div.sv
// tb_ln_arg_div: scoreboard bench for ln_arg_div; expectations follow LN_ARG_DIV_ROUND_EN when defined.
module tb_ln_arg_div;
  import ln_arg_div_pkg::*;
  typedef struct {
    longint data;
    logic err;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  logic signed [31:0] iData;
  logic pre_vaild;
  logic signed [31:0] oData;
  logic post_vaild;
  logic oErr;
  exp_t sb[$];
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int pulses = 0;
  bit count_pulses = 1'b0;
`ifdef LN_ARG_DIV_ROUND_EN
  localparam longint E4 = 39322;
  localparam longint E5 = 43691;
`else
  localparam longint E4 = 39321;
  localparam longint E5 = 43690;
`endif
  ln_arg_div dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iData      (iData),
    .pre_vaild  (pre_vaild),
    .oData      (oData),
    .post_vaild (post_vaild),
    .oErr       (oErr)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic longint golden(input longint x);
    longint n, d, m;
    n = x - 65536;
    d = x + 65536;
    if (n < 0) n = -n;
`ifdef LN_ARG_DIV_ROUND_EN
    m = ((n * 131072) / d + 1) / 2;
    if (m > 65535) m = 65535;
`else
    m = (n * 65536) / d;
`endif
    return (x < 65536) ? -m : m;
  endfunction
  task automatic send(input logic signed [31:0] x, input longint e, input logic er);
    @(posedge clk);
    #1;
    iData = x;
    pre_vaild = 1'b1;
    sb.push_back('{e, er, cyc + LATENCY});
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      pre_vaild = 1'b0;
      iData = $urandom;
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    chk("drain_queue_empty", sb.size(), 0);
  endtask
  always @(negedge clk)
    if (rst_n && post_vaild) begin
      if (count_pulses) pulses++;
      if (sb.size() == 0) chk("unexpected_post_vaild", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("oData", oData, e.data);
        chk("oErr", oErr, e.err);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  initial begin
    rst_n = 1'b0;
    pre_vaild = 1'b0;
    iData = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_oData", oData, 0);
    chk("reset_post_vaild", post_vaild, 0);
    chk("reset_oErr", oErr, 0);
    rst_n = 1'b1;
    idle(2);
    send(196608, 32768, 0);
    idle(3);
    send(65536, 0, 0);
    idle(1);
    send(32768, -21845, 0);
    idle(2);
    send(327680, E5, 0);
    idle(1);
    send(32'sh7fffffff, 65532, 0);
    idle(1);
    send(1, -65534, 0);
    idle(1);
    send(0, 0, 1);
    send(-65536, 0, 1);
    idle(1);
    drain();
    send(131072, 21845, 0);
    send(196608, 32768, 0);
    send(262144, E4, 0);
    send(327680, E5, 0);
    send(393216, 46811, 0);
    idle(3);
    send(196608, 32768, 0);
    idle(1);
    drain();
    for (int i = 0; i < 8; i++) begin
      logic signed [31:0] x;
      x = 32'($urandom_range(32'h7fffffff, 1));
      send(x, golden(longint'(x)), 0);
    end
    idle(1);
    drain();
    for (int i = 0; i < 12; i++) send(131072, 21845, 0);
    idle(1);
    for (int i = 0; i < 40 && sb.size() > 10; i++) begin
      @(negedge clk);
      #2;
    end
    chk("inflight_before_reset", sb.size(), 10);
    rst_n = 1'b0;
    #1;
    chk("async_clear_oData", oData, 0);
    chk("async_clear_post_vaild", post_vaild, 0);
    chk("async_clear_oErr", oErr, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_pulses = 1'b1;
    repeat (30) @(posedge clk);
    count_pulses = 1'b0;
    chk("pulses_after_reset", pulses, 0);
    send(327680, E5, 0);
    idle(1);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
